// File: rtl/imem_fetch_resp_if.sv
// imem_fetch_resp_if
//   Fetch request/response handshake plus the program-loader write port for
//   the instruction-memory responder.
//   master : fetch side / loader (drives requests, rsp_ready and load strobes)
//   slave  : the responder (drives req_ready and the response)
//   Signals:
//     req_valid/req_ready/req_addr     fetch request handshake, byte PC
//     rsp_valid/rsp_ready              response handshake
//     rsp_inst/rsp_err                 instruction word and access fault
//     load_en/load_addr/load_data      loader write port
interface imem_fetch_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic        rsp_err;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    modport master (
        output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data,
        output req_ready, rsp_valid, rsp_inst, rsp_err
    );
endinterface

// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp
//   Instruction-memory responder for the core fetch side. Accepts one
//   PC-addressed request at a time and returns the word after LATENCY
//   cycles over a valid/ready response handshake. A loader port writes the
//   word array at any time.
//   Ports:
//     clk_i     rising-edge clock
//     reset_i   synchronous active-high reset (word array is not cleared)
//     imem_io   imem_fetch_resp_if.slave: request, response and loader port
//   Optional feature:
//     IMEM_MISALIGN_CHK_EN  when defined, requests with req_addr[1:0]!=0
//                           return rsp_err=1 / rsp_inst=0.
//
//   state | meaning
//   IDLE  | req_ready=1, waiting for a fetch request
//   WAIT  | request latched, counting down remaining latency
//   RESP  | rsp_valid=1, word held until rsp_ready
module imem_fetch_resp #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned CNT_W      = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    imem_fetch_resp_if.slave  imem_io
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int unsigned     DEPTH  = 2 ** DEPTH_LOG2;
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_1  = CNT_W'(1);

    logic [31:0]      mem_q [DEPTH];

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      inst_q, inst_d;
    logic             err_q, err_d;
    logic             capture;

    // With LATENCY==1 the word is captured on the accept edge itself, so the
    // read path must look at the live request address rather than addr_q.
    logic [31:0]           rd_addr;
    logic [31:0]           rd_off;
    logic                  rd_in;
    logic                  rd_mis;
    logic                  rd_err;
    logic [DEPTH_LOG2-1:0] rd_idx;

    logic [31:0]           ld_off;
    logic                  ld_in;
    logic [DEPTH_LOG2-1:0] ld_idx;

    assign rd_addr = (state_q == ST_IDLE) ? imem_io.req_addr : addr_q;
    // Addresses below BASE wrap to a huge offset and fall out of range.
    assign rd_off  = rd_addr - BASE;
    assign rd_in   = (rd_off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign rd_idx  = rd_off[DEPTH_LOG2+1:2];
`ifdef IMEM_MISALIGN_CHK_EN
    assign rd_mis  = rd_addr[1:0] != 2'b00;
`else
    assign rd_mis  = 1'b0;
`endif
    assign rd_err  = !rd_in || rd_mis;

    assign ld_off  = imem_io.load_addr - BASE;
    assign ld_in   = (ld_off >> (DEPTH_LOG2 + 2)) == 32'd0;
    assign ld_idx  = ld_off[DEPTH_LOG2+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        err_d   = err_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (imem_io.req_valid) begin
                    addr_d = imem_io.req_addr;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        capture = 1'b1;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_1;
                if (cnt_q == CNT_1) begin
                    state_d = ST_RESP;
                    capture = 1'b1;
                end
            end
            ST_RESP: begin
                if (imem_io.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Array read happens before this edge's loader write lands (read-old).
        if (capture) begin
            inst_d = rd_err ? 32'h0 : mem_q[rd_idx];
            err_d  = rd_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (imem_io.load_en && ld_in) begin
            mem_q[ld_idx] <= imem_io.load_data;
        end
    end

    assign imem_io.req_ready = (state_q == ST_IDLE);
    assign imem_io.rsp_valid = (state_q == ST_RESP);
    assign imem_io.rsp_inst  = inst_q;
    assign imem_io.rsp_err   = err_q;
endmodule
